// File: rtl/memory_access_if.sv
// Execute-to-memory request and memory-to-write-back response bundle.
interface memory_access_if;
  logic [2:0]  stage;
  logic        memRead;
  logic        memWrite;
  logic        memToReg;
  logic [1:0]  size;
  logic        unsignedLoad;
  logic [31:0] aluResult;
  logic [31:0] writeData;
  logic        regWriteIn;
  logic        regDestIn;
  logic [5:0]  address1In;
  logic [5:0]  address2In;
  logic [31:0] value;
  logic        regWrite;
  logic        regDest;
  logic [5:0]  address1;
  logic [5:0]  address2;
  logic        done;
  logic        misaligned;

  modport master (
    output stage, memRead, memWrite, memToReg, size, unsignedLoad, aluResult,
           writeData, regWriteIn, regDestIn, address1In, address2In,
    input  value, regWrite, regDest, address1, address2, done, misaligned
  );

  modport slave (
    input  stage, memRead, memWrite, memToReg, size, unsignedLoad, aluResult,
           writeData, regWriteIn, regDestIn, address1In, address2In,
    output value, regWrite, regDest, address1, address2, done, misaligned
  );
endinterface

// File: rtl/memory_access.sv
// Multicycle MIPS memory-access stage: latches execute results at stage 3,
// performs an optional byte/half/word load or store with fixed wait states.
module memory_access #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clock,
  input  logic            reset,
  memory_access_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, FINISH} state_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        to_reg;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic        reg_write;
    logic        reg_dest;
    logic [5:0]  a1;
    logic [5:0]  a2;
  } req_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_t          req_q, req_d, req_in, src;

  logic [31:0]   value_q, value_d;
  logic          reg_write_q, reg_write_d;
  logic          reg_dest_q, reg_dest_d;
  logic [5:0]    a1_q, a1_d, a2_q, a2_d;
  logic          done_q, done_d;
  logic          mis_q, mis_d;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] widx;
  logic [31:0]   rword, shifted, ld_data, mem_wdata;
  logic [3:0]    mem_be;
  logic          is_acc, misal, fin, mem_we;

  always_comb begin
    req_in.rd        = bus.memRead;
    req_in.wr        = bus.memWrite;
    req_in.to_reg    = bus.memToReg;
    req_in.size      = bus.size;
    req_in.uns       = bus.unsignedLoad;
    req_in.alu       = bus.aluResult;
    req_in.wdata     = bus.writeData;
    req_in.reg_write = bus.regWriteIn;
    req_in.reg_dest  = bus.regDestIn;
    req_in.a1        = bus.address1In;
    req_in.a2        = bus.address2In;
  end

  // In IDLE the operation is decoded straight from the inputs so the
  // zero-wait path can finish at the capture edge itself.
  always_comb begin
    src     = (state_q == IDLE) ? req_in : req_q;
    is_acc  = src.rd | src.wr;
    misal   = is_acc & (((src.size == 2'b01) & src.alu[0]) |
                        (src.size[1] & (src.alu[1:0] != 2'b00)));
    widx    = src.alu[AW+1:2];
    rword   = mem_q[widx];
    shifted = rword >> {src.alu[1:0], 3'b000};
    case (src.size)
      2'b00: begin
        ld_data   = src.uns ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        mem_be    = 4'b0001 << src.alu[1:0];
        mem_wdata = {4{src.wdata[7:0]}};
      end
      2'b01: begin
        ld_data   = src.uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        mem_be    = src.alu[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{src.wdata[15:0]}};
      end
      default: begin
        ld_data   = rword;
        mem_be    = 4'b1111;
        mem_wdata = src.wdata;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    fin     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.stage == 3'd3) begin
          req_d = req_in;
          if (misal || !is_acc || (WAIT_CYCLES == 0)) begin
            state_d = FINISH;
            fin     = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) begin
          state_d = FINISH;
          fin     = 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Results are registered at the edge entering FINISH, so they are valid
  // during the done cycle and held until the next completion.
  always_comb begin
    value_d     = value_q;
    reg_write_d = reg_write_q;
    reg_dest_d  = reg_dest_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    done_d      = fin;
    mis_d       = fin & misal;
    mem_we      = fin & src.wr & ~misal;
    if (fin) begin
      value_d     = (!misal && src.rd && src.to_reg && !src.wr) ? ld_data : src.alu;
      reg_write_d = src.reg_write & ~misal;
      reg_dest_d  = src.reg_dest;
      a1_d        = src.a1;
      a2_d        = src.a2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      value_q     <= '0;
      reg_write_q <= 1'b0;
      reg_dest_q  <= 1'b0;
      a1_q        <= '0;
      a2_q        <= '0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      value_q     <= value_d;
      reg_write_q <= reg_write_d;
      reg_dest_q  <= reg_dest_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      done_q      <= done_d;
      mis_q       <= mis_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int k = 0; k < 4; k++)
        if (mem_be[k]) mem_q[widx][8*k +: 8] <= mem_wdata[8*k +: 8];
    end
  end

  assign bus.value      = value_q;
  assign bus.regWrite   = reg_write_q;
  assign bus.regDest    = reg_dest_q;
  assign bus.address1   = a1_q;
  assign bus.address2   = a2_q;
  assign bus.done       = done_q;
  assign bus.misaligned = mis_q;
endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access against a byte-array reference model.
module tb_memory_access;
  localparam int DEPTH = 256;
  localparam int W     = 2;
  localparam int MEMB  = 4 * DEPTH;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  memory_access_if bus();

  memory_access #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave)
  );

  typedef struct {
    int          cyc;
    logic [31:0] value;
    logic        rw, rdst, mis, single, held;
    logic [5:0]  a1, a2;
  } obs_t;

  typedef struct {
    int          cyc;
    logic [31:0] value;
    logic        rw, mis;
  } exp_t;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] ref_mem [MEMB];

  function automatic void clear_ref();
    for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'h00;
  endfunction

  // Behavioural model: memory as a flat byte array, address modulo its size.
  function automatic exp_t model(input logic rd, wr, to_reg, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] alu, wd,
                                 input logic rwi);
    exp_t e;
    int n, base;
    logic [31:0] ld;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = int'(alu % MEMB);
    e.mis = (rd || wr) && ((alu % n) != 0);
    e.cyc = (!(rd || wr) || e.mis) ? 1 : 1 + W;
    e.rw  = rwi && !e.mis;
    e.value = alu;
    if (wr && !e.mis)
      for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8*i +: 8];
    if (rd && to_reg && !wr && !e.mis) begin
      ld = 32'h0;
      for (int i = 0; i < n; i++) ld = ld | (32'(ref_mem[base + i]) << (8 * i));
      if (n < 4 && !uns && ld[8*n-1]) ld = ld | ~((32'h1 << (8 * n)) - 32'h1);
      e.value = ld;
    end
    return e;
  endfunction

  task automatic drive(input logic rd, wr, to_reg, input logic [1:0] sz, input logic uns,
                       input logic [31:0] alu, wd, input logic rwi, rdi,
                       input logic [5:0] a1, a2);
    bus.memRead = rd; bus.memWrite = wr; bus.memToReg = to_reg; bus.size = sz;
    bus.unsignedLoad = uns; bus.aluResult = alu; bus.writeData = wd;
    bus.regWriteIn = rwi; bus.regDestIn = rdi; bus.address1In = a1; bus.address2In = a2;
  endtask

  // Issue one operation and gather what the DUT presents at done.
  task automatic do_op(input logic rd, wr, to_reg, input logic [1:0] sz, input logic uns,
                       input logic [31:0] alu, wd, input logic rwi, rdi,
                       input logic [5:0] a1, a2, output obs_t o);
    drive(rd, wr, to_reg, sz, uns, alu, wd, rwi, rdi, a1, a2);
    bus.stage = 3'd3;
    @(posedge clock); #1;
    bus.stage = 3'd0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, $urandom, $urandom, 1'b0, 1'b0, 6'd0, 6'd0);
    o.cyc = 1;
    while (bus.done !== 1'b1 && o.cyc < 30) begin
      @(posedge clock); #1;
      o.cyc++;
    end
    o.value = bus.value; o.rw = bus.regWrite; o.rdst = bus.regDest;
    o.a1 = bus.address1; o.a2 = bus.address2; o.mis = bus.misaligned;
    @(posedge clock); #1;
    o.single = (bus.done === 1'b0) && (bus.misaligned === 1'b0);
    o.held   = (bus.value === o.value) && (bus.regWrite === o.rw);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    clear_ref();
    tests_run++;
    if ({bus.value, bus.regWrite, bus.regDest, bus.address1, bus.address2} !== 46'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got value=%h rw=%b rd=%b a1=%h a2=%h, want all 0",
               bus.value, bus.regWrite, bus.regDest, bus.address1, bus.address2);
    end
    tests_run++;
    if ({bus.done, bus.misaligned} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_pulses: got done=%b mis=%b, want 0 0", bus.done, bus.misaligned);
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_sw_lw();
    obs_t o; exp_t e;
    do_op(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0, 6'd0, o);
    e = model(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    tests_run++;
    if (o.cyc !== e.cyc) begin
      tests_failed++; $display("FAIL sw_latency: got %0d want %0d", o.cyc, e.cyc);
    end
    do_op(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 6'd9, 6'd17, o);
    e = model(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    tests_run++;
    if (o.value !== 32'hDEADBEEF || o.value !== e.value) begin
      tests_failed++; $display("FAIL lw_value: got %h want %h", o.value, 32'hDEADBEEF);
    end
    tests_run++;
    if (o.cyc !== 3) begin
      tests_failed++; $display("FAIL lw_latency: got %0d want 3", o.cyc);
    end
    tests_run++;
    if ({o.rw, o.rdst, o.a1, o.a2} !== {1'b1, 1'b1, 6'd9, 6'd17}) begin
      tests_failed++;
      $display("FAIL lw_forward: got rw=%b rd=%b a1=%0d a2=%0d want 1 1 9 17", o.rw, o.rdst, o.a1, o.a2);
    end
  endtask

  task automatic test_sb_lb();
    obs_t o; exp_t e;
    do_op(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h21, 32'h12345680, 1'b0, 1'b0, 6'd0, 6'd0, o);
    e = model(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h21, 32'h12345680, 1'b0);
    do_op(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h0, 1'b1, 1'b0, 6'd1, 6'd2, o);
    e = model(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h0, 1'b1);
    tests_run++;
    if (o.value !== 32'hFFFFFF80 || o.value !== e.value) begin
      tests_failed++; $display("FAIL lb_value: got %h want FFFFFF80", o.value);
    end
    do_op(1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 32'h21, 32'h0, 1'b1, 1'b0, 6'd1, 6'd2, o);
    tests_run++;
    if (o.value !== 32'h00000080) begin
      tests_failed++; $display("FAIL lbu_value: got %h want 00000080", o.value);
    end
    do_op(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 6'd1, 6'd2, o);
    tests_run++;
    if (o.value !== 32'h00008000) begin
      tests_failed++; $display("FAIL sb_lanes: got %h want 00008000", o.value);
    end
  endtask

  task automatic test_misaligned();
    obs_t o; exp_t e;
    do_op(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h02, 32'h0, 1'b1, 1'b0, 6'd3, 6'd4, o);
    tests_run++;
    if ({o.cyc == 1, o.mis, o.rw, o.value} !== {1'b1, 1'b1, 1'b0, 32'h2}) begin
      tests_failed++;
      $display("FAIL mis_lw: got cyc=%0d mis=%b rw=%b value=%h want 1 1 0 00000002", o.cyc, o.mis, o.rw, o.value);
    end
    tests_run++;
    if (o.single !== 1'b1) begin
      tests_failed++; $display("FAIL mis_pulse: got done/mis still high next cycle, want single pulse");
    end
    do_op(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 32'h03, 32'hFFFFFFFF, 1'b1, 1'b0, 6'd3, 6'd4, o);
    tests_run++;
    if ({o.cyc == 1, o.mis, o.rw, o.value} !== {1'b1, 1'b1, 1'b0, 32'h3}) begin
      tests_failed++;
      $display("FAIL mis_sh: got cyc=%0d mis=%b rw=%b value=%h want 1 1 0 00000003", o.cyc, o.mis, o.rw, o.value);
    end
    do_op(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 6'd3, 6'd4, o);
    e = model(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h00, 32'h0, 1'b1);
    tests_run++;
    if (o.value !== e.value) begin
      tests_failed++; $display("FAIL mis_untouched: got %h want %h", o.value, e.value);
    end
  endtask

  task automatic test_passthrough();
    obs_t o;
    do_op(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b1, 6'd33, 6'd44, o);
    tests_run++;
    if ({o.cyc == 1, o.value, o.rw, o.mis} !== {1'b1, 32'h12345678, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL passthrough: got cyc=%0d value=%h rw=%b mis=%b want 1 12345678 1 0", o.cyc, o.value, o.rw, o.mis);
    end
  endtask

  task automatic test_reset_mid_wait();
    obs_t o;
    int dones = 0;
    drive(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h44, 32'hCAFEF00D, 1'b0, 1'b0, 6'd0, 6'd0);
    bus.stage = 3'd3;
    @(posedge clock); #1;
    bus.stage = 3'd0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    clear_ref();
    for (int i = 0; i < 6; i++) begin
      if (bus.done === 1'b1) dones++;
      @(posedge clock); #1;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++; $display("FAIL rst_wait_done: got %0d done pulses want 0", dones);
    end
    do_op(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h44, 32'h0, 1'b1, 1'b0, 6'd0, 6'd0, o);
    tests_run++;
    if (o.value !== 32'h0) begin
      tests_failed++; $display("FAIL rst_wait_drop: got %h want 00000000", o.value);
    end
  endtask

  task automatic test_wrap_busy();
    obs_t o; exp_t e;
    int dones = 0;
    do_op(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'(MEMB), 32'hA5A5A5A5, 1'b0, 1'b0, 6'd0, 6'd0, o);
    e = model(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'(MEMB), 32'hA5A5A5A5, 1'b0);
    do_op(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 6'd0, 6'd0, o);
    e = model(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
    tests_run++;
    if (o.value !== 32'hA5A5A5A5 || o.value !== e.value) begin
      tests_failed++; $display("FAIL wrap: got %h want A5A5A5A5", o.value);
    end
    // Keep stage at 3 through WAIT and FINISH; only one completion may occur.
    drive(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 32'h01020304, 1'b0, 1'b0, 6'd0, 6'd0);
    bus.stage = 3'd3;
    @(posedge clock); #1;
    for (int i = 0; i < W + 1; i++) begin
      @(posedge clock); #1;
      if (bus.done === 1'b1) dones++;
    end
    bus.stage = 3'd0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (bus.done === 1'b1) dones++;
    end
    e = model(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 32'h01020304, 1'b0);
    tests_run++;
    if (dones !== 1) begin
      tests_failed++; $display("FAIL busy_single: got %0d done pulses want 1", dones);
    end
  endtask

  task automatic test_random();
    obs_t o; exp_t e;
    logic rd, wr, to_reg, uns, rwi, rdi;
    logic [1:0] sz;
    logic [31:0] alu, wd;
    logic [5:0] a1, a2;
    for (int t = 0; t < 60; t++) begin
      rd = 1'($urandom); wr = 1'($urandom_range(0, 2) == 0); to_reg = 1'($urandom_range(0, 3) != 0);
      uns = 1'($urandom); rwi = 1'($urandom); rdi = 1'($urandom);
      sz = 2'($urandom); wd = $urandom; a1 = 6'($urandom); a2 = 6'($urandom);
      alu = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) alu = alu | ($urandom & ~32'(MEMB - 1));
      do_op(rd, wr, to_reg, sz, uns, alu, wd, rwi, rdi, a1, a2, o);
      e = model(rd, wr, to_reg, sz, uns, alu, wd, rwi);
      tests_run++;
      if ({o.cyc, o.value, o.rw, o.mis} !== {e.cyc, e.value, e.rw, e.mis} ||
          {o.rdst, o.a1, o.a2} !== {rdi, a1, a2} || !o.single || !o.held) begin
        tests_failed++;
        $display("FAIL random[%0d] rd=%b wr=%b sz=%0d alu=%h: got cyc=%0d val=%h rw=%b mis=%b rdst=%b a1=%0d a2=%0d single=%b held=%b want cyc=%0d val=%h rw=%b mis=%b rdst=%b a1=%0d a2=%0d",
                 t, rd, wr, sz, alu, o.cyc, o.value, o.rw, o.mis, o.rdst, o.a1, o.a2, o.single, o.held,
                 e.cyc, e.value, e.rw, e.mis, rdi, a1, a2);
      end
    end
  endtask

  initial begin
    bus.stage = 3'd0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0, 6'd0);
    test_reset();
    test_sw_lw();
    test_sb_lb();
    test_misaligned();
    test_passthrough();
    test_reset_mid_wait();
    test_wrap_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/memory_access.md
# memory_access

Memory-access stage of the multicycle MIPS datapath. While `stage` is 3 it captures the ALU result and control bits from execute and performs an optional load or store against an internal data memory. The data memory has a fixed number of wait states. On completion it presents the write-back value, with register-write control and destination addresses, to the write-back stage, which acts on them at `stage` 4. It supports byte/half/word loads and stores, sign/zero extension and alignment checking.

## Interface
- `DEPTH_WORDS`, 256: data memory depth in 32-bit words (power of two).
- `WAIT_CYCLES`, 2: extra cycles a memory access takes beyond the minimum; 0 is legal.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `stage`  in  3  pipeline stage counter; 3 = memory stage.
- `memRead`, `memWrite`  in  1 each  load / store request.
- `memToReg`  in  1  1: write-back value is load data; 0: value is `aluResult`.
- `size`  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- `unsignedLoad`  in  1  1: zero-extend byte/half loads; 0: sign-extend.
- `aluResult`  in  32  effective byte address, or pass-through result.
- `writeData`  in  32  store data; low byte/half used for sb/sh.
- `regWriteIn`, `regDestIn`  in  1 each  forwarded to write-back.
- `address1In`, `address2In`  in  6 each  forwarded destination addresses.
- `value`  out  32  write-back data.
- `regWrite`, `regDest`  out  1 each  registered copies for write-back.
- `address1`, `address2`  out  6 each  registered copies.
- `done`  out  1  one-cycle pulse: outputs are valid.
- `misaligned`  out  1  one-cycle pulse with `done`: alignment fault.

## Operation
- FSM states: IDLE, WAIT, FINISH.
- **IDLE**
  - At a clock edge with `stage`==3, latch all inputs.
  - If the access is misaligned, or `memRead`=`memWrite`=0, go to FINISH.
  - Otherwise load a wait counter with `WAIT_CYCLES` and go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - At 0 go to FINISH. With `WAIT_CYCLES`=0, WAIT lasts zero cycles: go directly to FINISH.
- **FINISH**
  - Perform the memory operation, drive the outputs, pulse `done`, return to IDLE.
- Word index is `aluResult[log2(DEPTH_WORDS)+1:2]`; upper address bits are ignored, so addresses wrap.
- Byte lanes are little-endian: byte k occupies bits [8k+7:8k].
- Store:
  - sb writes only lane `addr[1:0]`.
  - sh writes lanes `addr[1]*2` and `addr[1]*2+1`.
  - sw writes all lanes.
  - Other lanes are unchanged.
- Load: select the lane(s) the same way, then sign- or zero-extend per `unsignedLoad`; word loads are not extended.
- `memWrite` and `memRead` both set: the store executes, the read is ignored, and `value`=`aluResult`.
- Misaligned fault:
  - Condition: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Response: no memory write, `regWrite` forced 0, `misaligned`=1, `value`=`aluResult`.
- `value` = extended load data if `memToReg`=1 and `memRead`=1; otherwise `aluResult`.
- `regWrite`, `regDest`, `address1`, `address2` are the latched inputs, except that a fault forces `regWrite`=0.
- `stage`==3 seen while in WAIT or FINISH is ignored; no re-capture.

## Timing
- Inputs are captured at edge N.
- No-memory or misaligned access: `done`=1 in cycle N+1.
- Load/store: `done`=1 in cycle N+1+`WAIT_CYCLES`; the memory write commits at that same edge.
- Outputs change only at the `done` edge and hold until the next `done`, so write-back samples them at `stage`==4.
- `done` and `misaligned` are single-cycle pulses.
- Reset (any state, including mid-WAIT):
  - State returns to IDLE.
  - All outputs go to 0.
  - The in-flight store is dropped.
  - All memory words are cleared to 0.
- Reset has priority over a simultaneous `stage`==3 capture.
- Back-to-back: a new capture is possible in the cycle after `done`.

## Test plan
- **sw then lw**
  - Stimulus: sw 0xDEADBEEF at 0x10, then lw 0x10 with `memToReg`=1.
  - Required: load gives `value`=0xDEADBEEF, `done` at N+3 with default wait states, `regWrite` and `address1` forwarded.
- **sb then lb/lbu**
  - Stimulus: sb 0x80 at 0x21, then lb 0x21, then lbu 0x21.
  - Required: lb gives 0xFFFFFF80; lbu gives 0x00000080.
  - Required: lw 0x20 gives 0x00008000, showing the other lanes are unchanged.
- **Misaligned**
  - Stimulus: lw 0x02 with `regWriteIn`=1.
  - Required: `done`=`misaligned`=1 at N+1, `regWrite`=0, `value`=0x00000002, memory untouched.
  - Stimulus: sh 0x03.
  - Required: same fault response.
- **Pass-through**
  - Stimulus: `memRead`=`memWrite`=0, `aluResult`=0x12345678.
  - Required: `value`=0x12345678 at N+1, no memory change.
- **Reset mid-WAIT**
  - Stimulus: assert `reset` during a sw wait cycle, then lw the same address.
  - Required: no `done` for the sw; the later lw returns 0.
- **Wrap and busy**
  - Stimulus: sw 0xA5A5A5A5 at byte address 4×`DEPTH_WORDS`.
  - Required: lw 0 returns 0xA5A5A5A5.
  - Stimulus: hold `stage`==3 during WAIT.
  - Required: exactly one `done`.
